// File: rtl/issue_scoreboard_pkg.sv
// Shared CPU definitions for the issue scoreboard: RV32 major opcodes,
// mul/div sequencer state encoding and source-operand usage helpers.
package issue_scoreboard_pkg;

  // Instruction bits [6:2] of the major opcodes the hazard logic cares about.
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // Mul/div sequencer states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // rs1 is read by everything except the upper-immediate forms and JAL.
  function automatic logic rs1_used(input logic [4:0] opcode);
    return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  endfunction

  // rs2 is read only by register-register ALU ops, stores and branches.
  function automatic logic rs2_used(input logic [4:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/writeback bundle between the decode stage and the issue scoreboard.
//
// Handshake: id_valid is the offer and id_issue the accept. An instruction
// leaves decode on exactly the cycles where id_issue is high; while id_stall
// is high decode must hold every id_* field stable. An illegal instruction
// (id_illegal) is never accepted and never stalls; decode disposes of it.
// wb_valid is a one-cycle event with no back-pressure.
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  logic        id_valid;
  logic [4:0]  id_opcode;
  logic [2:0]  id_func3;
  logic        id_func7_mul;
  logic [1:0]  id_last2;
  logic [4:0]  id_rs1_index;
  logic [4:0]  id_rs2_index;
  logic [4:0]  id_rd_index;
  logic        wb_valid;
  logic [4:0]  wb_rd_index;

  logic        id_issue;
  logic        id_stall;
  logic        id_illegal;
  logic        md_start;
  logic        md_is_div;
  logic        md_busy;
  logic        md_done;

  // Observability: registered pending vector and sequencer state.
  logic [31:0] dbg_pending;
  md_state_e   dbg_md_state;

  modport master (
    output id_valid, id_opcode, id_func3, id_func7_mul, id_last2,
           id_rs1_index, id_rs2_index, id_rd_index, wb_valid, wb_rd_index,
    input  id_issue, id_stall, id_illegal, md_start, md_is_div, md_busy,
           md_done, dbg_pending, dbg_md_state
  );

  modport slave (
    input  id_valid, id_opcode, id_func3, id_func7_mul, id_last2,
           id_rs1_index, id_rs2_index, id_rd_index, wb_valid, wb_rd_index,
    output id_issue, id_stall, id_illegal, md_start, md_is_div, md_busy,
           md_done, dbg_pending, dbg_md_state
  );

endinterface

// File: rtl/issue_scoreboard_md_seq.sv
// Mul/div sequencer: tracks the fixed execute latency of the single
// multi-cycle mul/div unit. IDLE -> BUSY on start, BUSY counts down to zero,
// then one DONE cycle which may immediately accept the next start.
module md_seq
  import issue_scoreboard_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      start_div,
  output logic      busy,
  output logic      done,
  output logic      is_div,
  output md_state_e state
);

  localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  // Counter holds at most MAX_CYC-1.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;

  // State, countdown and op-kind registers; reset drops any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

  // Next-state and countdown; a start in DONE chains straight into BUSY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    case (state_q)
      MD_IDLE, MD_DONE: begin
        if (start) begin
          state_d  = MD_BUSY;
          cnt_d    = start_div ? DIV_LOAD : MUL_LOAD;
          is_div_d = start_div;
        end else begin
          state_d  = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy   = (state_q != MD_IDLE);
    done   = (state_q == MD_DONE);
    is_div = is_div_q;
    state  = state_q;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: holds decode on RAW/WAW hazards against long-latency
// destinations (loads and M-ops) and on a busy mul/div unit, and tracks
// which registers still await a long-latency writeback.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic               clk,
  input  logic               rst,
  issue_scoreboard_if.slave  sb
);

  logic [31:0] pending_q, pending_d;
  logic        is_mop, is_div_op, is_long, illegal, legal;
  logic        raw_hazard, waw_hazard, md_hazard;
  logic        stall, issue, start;
  logic        md_busy, md_done, md_is_div;
  md_state_e   md_state;

  // Instruction classification and hazard detection from registered pending
  // state only; a same-cycle writeback does not release a stall.
  always_comb begin
    is_mop     = (sb.id_opcode == OPC_OP) && sb.id_func7_mul;
    is_div_op  = is_mop && sb.id_func3[2];
    is_long    = (sb.id_opcode == OPC_LOAD) || is_mop;
    illegal    = sb.id_valid && (sb.id_last2 != 2'b11);
    legal      = sb.id_valid && !illegal;
    raw_hazard = (rs1_used(sb.id_opcode) && pending_q[sb.id_rs1_index]) ||
                 (rs2_used(sb.id_opcode) && pending_q[sb.id_rs2_index]);
    waw_hazard = is_long && pending_q[sb.id_rd_index];
    md_hazard  = is_mop && (md_state == MD_BUSY);
    stall      = legal && (raw_hazard || waw_hazard || md_hazard);
    issue      = legal && !stall;
    start      = issue && is_mop;
  end

  // Pending update: writeback clears first so a same-index issue wins.
  always_comb begin
    pending_d = pending_q;
    if (sb.wb_valid) begin
      pending_d[sb.wb_rd_index] = 1'b0;
    end
    if (issue && is_long && (sb.id_rd_index != 5'd0)) begin
      pending_d[sb.id_rd_index] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending register; cleared asynchronously with no regard to in-flight ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  md_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_div (is_div_op),
    .busy      (md_busy),
    .done      (md_done),
    .is_div    (md_is_div),
    .state     (md_state)
  );

  assign sb.id_issue     = issue;
  assign sb.id_stall     = stall;
  assign sb.id_illegal   = illegal;
  assign sb.md_start     = start;
  assign sb.md_is_div    = md_is_div;
  assign sb.md_busy      = md_busy;
  assign sb.md_done      = md_done;
  assign sb.dbg_pending  = pending_q;
  assign sb.dbg_md_state = md_state;

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 2, multiply execute latency in cycles (>=1).
REQ-002 SHALL have parameter DIV_CYCLES, default 33, divide/remainder execute latency in cycles (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 id_valid  input  1  decode stage holds an instruction.
REQ-006 id_opcode  input  5  instruction bits [6:2].
REQ-007 id_func3  input  3  instruction bits [14:12].
REQ-008 id_func7_mul  input  1  instruction bit [25].
REQ-009 id_last2  input  2  instruction bits [1:0].
REQ-010 id_rs1_index / id_rs2_index / id_rd_index  input  5 each  register indices.
REQ-011 wb_valid  input  1  writeback of a long-latency result this cycle; wb_rd_index  input  5  its destination.
REQ-012 id_issue  output  1  instruction leaves decode this cycle.
REQ-013 id_stall  output  1  decode must hold its instruction.
REQ-014 id_illegal  output  1  id_valid with id_last2 != 2'b11.
REQ-015 md_start  output  1  one-cycle start pulse to mul/div unit; md_is_div  output  1  started op is div/rem.
REQ-016 md_busy  output  1  mul/div FSM not IDLE; md_done  output  1  one-cycle pulse, last execute cycle finished.

Function
REQ-017 Long op = LOAD (opcode 00000) or M-op (opcode 01100 with id_func7_mul=1); M-op is div when id_func3[2]=1.
REQ-018 Source use: rs1 used unless opcode is LUI 01101, AUIPC 00101, JAL 11011; rs2 used only for OP 01100, STORE 01000, BRANCH 11000.
REQ-019 Scoreboard: 32-bit pending vector; bit 0 always 0.
REQ-020 id_stall = id_valid & !id_illegal & (used rs pending | (long op & rd pending) | (M-op & FSM in BUSY)).
REQ-021 id_issue = id_valid & !id_illegal & !id_stall; id_illegal instructions never issue and never stall.
REQ-022 On issue of a long op with rd != 0, pending[rd] sets next edge.
REQ-023 On wb_valid, pending[wb_rd_index] clears next edge; same-cycle set and clear of the same index: set wins.
REQ-024 wb_valid to an index not pending: no effect.
REQ-025 FSM states IDLE, BUSY, DONE; md_start = issue of M-op (combinational, same cycle).
REQ-026 IDLE/DONE + md_start -> BUSY, counter loaded (DIV_CYCLES or MUL_CYCLES) - 1.
REQ-027 BUSY: counter decrements each cycle; at counter 0 -> DONE.
REQ-028 DONE: md_done=1 for that cycle; without md_start -> IDLE.
REQ-029 Latency-1 ops: BUSY lasts exactly one cycle, DONE next.
REQ-030 md_is_div registered at md_start, held until next md_start.
REQ-031 Stall/issue decisions use registered pending state only (no writeback bypass).

Reset
REQ-032 rst asserted: pending all 0, FSM IDLE, counter 0, md_is_div 0, md_done 0, md_busy 0, immediately and regardless of in-flight ops.
REQ-033 Combinational outputs with id_valid=0 during reset: id_issue, id_stall, id_illegal, md_start all 0.

Structure
REQ-034 Opcode constants (LOAD, STORE, OP, BRANCH, LUI, AUIPC, JAL) and FSM state enum SHALL live in the shared CPU package.
REQ-035 Mul/div sequencer FSM+counter SHALL be a sub-module md_seq; scoreboard and hazard logic stay in the top.

Verification
REQ-036 Issue LOAD rd=5, next cycle ADD rs1=5 -> id_stall=1 until wb_valid rd=5, issue the cycle after.
REQ-037 DIV rd=7 with defaults -> md_start 1 cycle, md_busy 33 BUSY cycles, md_done on the 34th; second MUL stalled throughout BUSY, issues in DONE.
REQ-038 Same-cycle issue LOAD rd=9 and wb_valid rd=9 -> pending[9]=1 afterwards.
REQ-039 LOAD rd=0 then ADD rs1=0 -> no stall; id_last2=2'b01 -> id_illegal=1, id_issue=0, id_stall=0.
REQ-040 rst asserted mid-divide (BUSY, pending[3]=1) -> md_busy=0 and pending clear without clock edge; dependent instruction issues after release.
REQ-041 LUI rd=4 with pending[rs1 field] set -> no stall (rs1 unused).
